// File: rtl/ctr_table_pkg.sv
// Shared types, constants and counter arithmetic for the two-bit-counter table updater.
package ctr_table_pkg;

  localparam int IDX_W   = 9;
  localparam int LANES   = 8;
  localparam int CTR_W   = 2;
  localparam int LANE_W  = 3;
  localparam int ENTRIES = 512;
  localparam logic [CTR_W-1:0] INIT_CTR = 2'b10;

  typedef logic [CTR_W-1:0]       ctr_t;
  typedef logic [LANES*CTR_W-1:0] entry_t;
  typedef logic [IDX_W-1:0]       idx_t;
  typedef logic [LANE_W-1:0]      lane_t;

  typedef struct packed {
    idx_t  idx;
    lane_t lane;
    logic  taken;
  } upd_req_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Saturating 2-bit step: taken counts up to 3, not-taken counts down to 0.
  function automatic ctr_t sat_update(ctr_t old, logic taken);
    if (taken) return (old == 2'b11) ? old : old + 2'd1;
    else       return (old == 2'b00) ? old : old - 2'd1;
  endfunction

  function automatic logic [LANES-1:0] lane_onehot(lane_t lane);
    lane_onehot       = '0;
    lane_onehot[lane] = 1'b1;
  endfunction

endpackage

// File: rtl/ctr_table_updater_bypass.sv
// Field merge: patches one lane of a raw macro word with the write issued in the same cycle as the read.
module ctr_lane_bypass
  import ctr_table_pkg::*;
(
  input  entry_t raw_i,
  input  idx_t   rd_idx_i,
  input  logic   lw_valid_i,
  input  idx_t   lw_idx_i,
  input  lane_t  lw_lane_i,
  input  ctr_t   lw_val_i,
  output entry_t word_o
);

  always_comb begin
    word_o = raw_i;
    if (lw_valid_i && (lw_idx_i == rd_idx_i)) begin
      word_o[int'(lw_lane_i)*CTR_W +: CTR_W] = lw_val_i;
    end
  end

endmodule

// File: rtl/ctr_table_updater.sv
// Control stage for the 512x16 counter macro: init sweep, lookup/RMW arbitration, write bypass.
// Optional perf counters are built when CTR_TABLE_UPD_PERF_EN is defined.
module ctr_table_updater
  import ctr_table_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   pred_valid,
  input  logic [IDX_W-1:0]       pred_idx,
  output logic                   pred_resp_valid,
  output logic [LANES*CTR_W-1:0] pred_data,
  input  logic                   upd_valid,
  output logic                   upd_ready,
  input  logic [IDX_W-1:0]       upd_idx,
  input  logic [LANE_W-1:0]      upd_lane,
  input  logic                   upd_taken,
  output logic                   init_done,
  output logic                   R0_en,
  output logic [IDX_W-1:0]       R0_addr,
  input  logic [LANES*CTR_W-1:0] R0_data,
  output logic                   W0_en,
  output logic [IDX_W-1:0]       W0_addr,
  output logic [LANES*CTR_W-1:0] W0_data,
  output logic [LANES-1:0]       W0_mask
`ifdef CTR_TABLE_UPD_PERF_EN
  ,
  output logic [31:0]            perf_upd_cnt,
  output logic [31:0]            perf_sat_cnt
`endif
);

  // Handshake: an update transfers in any cycle where upd_valid && upd_ready;
  // upd_ready is low in INIT and whenever a lookup claims the read port.

  state_e   state_q, state_d;
  logic     sweep_en_q;
  idx_t     cnt_q, cnt_d;
  logic     pred_v_q;
  idx_t     pred_idx_q;
  logic     s1_v_q;
  upd_req_t s1_q;
  logic     lw_v_q;
  idx_t     lw_idx_q;
  lane_t    lw_lane_q;
  ctr_t     lw_val_q;

  logic     pred_acc, upd_acc;
  entry_t   pred_word, s1_word;
  ctr_t     s1_old, s1_new;

  // init_done is the FSM state seen from outside.
  assign init_done = (state_q == ST_RUN);

  ctr_lane_bypass u_pred_byp (
    .raw_i      (R0_data),
    .rd_idx_i   (pred_idx_q),
    .lw_valid_i (lw_v_q),
    .lw_idx_i   (lw_idx_q),
    .lw_lane_i  (lw_lane_q),
    .lw_val_i   (lw_val_q),
    .word_o     (pred_word)
  );

  ctr_lane_bypass u_upd_byp (
    .raw_i      (R0_data),
    .rd_idx_i   (s1_q.idx),
    .lw_valid_i (lw_v_q),
    .lw_idx_i   (lw_idx_q),
    .lw_lane_i  (lw_lane_q),
    .lw_val_i   (lw_val_q),
    .word_o     (s1_word)
  );

  assign s1_old          = s1_word[int'(s1_q.lane)*CTR_W +: CTR_W];
  assign s1_new          = sat_update(s1_old, s1_q.taken);
  assign pred_resp_valid = pred_v_q;
  assign pred_data       = pred_v_q ? pred_word : '0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pred_acc  = 1'b0;
    upd_acc   = 1'b0;
    upd_ready = 1'b0;
    R0_en     = 1'b0;
    R0_addr   = '0;
    W0_en     = 1'b0;
    W0_addr   = '0;
    W0_data   = '0;
    W0_mask   = '0;
    case (state_q)
      ST_INIT: begin
        // sweep_en_q holds the sweep off until the first edge after reset release.
        if (sweep_en_q) begin
          W0_en   = 1'b1;
          W0_addr = cnt_q;
          W0_mask = '1;
          W0_data = {LANES{INIT_CTR}};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == idx_t'(ENTRIES - 1)) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (pred_valid) begin
          pred_acc = 1'b1;
          R0_en    = 1'b1;
          R0_addr  = pred_idx;
        end else begin
          upd_ready = 1'b1;
          if (upd_valid) begin
            upd_acc = 1'b1;
            R0_en   = 1'b1;
            R0_addr = upd_idx;
          end
        end
        if (s1_v_q) begin
          W0_en   = 1'b1;
          W0_addr = s1_q.idx;
          W0_mask = lane_onehot(s1_q.lane);
          W0_data = entry_t'(s1_new) << (int'(s1_q.lane) * CTR_W);
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      sweep_en_q <= 1'b0;
      cnt_q      <= '0;
      pred_v_q   <= 1'b0;
      pred_idx_q <= '0;
      s1_v_q     <= 1'b0;
      s1_q       <= '0;
      lw_v_q     <= 1'b0;
      lw_idx_q   <= '0;
      lw_lane_q  <= '0;
      lw_val_q   <= '0;
    end else begin
      state_q    <= state_d;
      sweep_en_q <= 1'b1;
      cnt_q      <= cnt_d;
      pred_v_q   <= pred_acc;
      if (pred_acc) pred_idx_q <= pred_idx;
      s1_v_q     <= upd_acc;
      if (upd_acc) s1_q <= '{idx: upd_idx, lane: upd_lane, taken: upd_taken};
      // Record of this cycle's update write, consumed by next cycle's returning read.
      lw_v_q     <= s1_v_q;
      lw_idx_q   <= s1_q.idx;
      lw_lane_q  <= s1_q.lane;
      lw_val_q   <= s1_new;
    end
  end

`ifdef CTR_TABLE_UPD_PERF_EN
  logic [31:0] upd_cnt_q, sat_cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      upd_cnt_q <= '0;
      sat_cnt_q <= '0;
    end else begin
      if (upd_acc) upd_cnt_q <= upd_cnt_q + 32'd1;
      if (s1_v_q && (s1_new == s1_old)) sat_cnt_q <= sat_cnt_q + 32'd1;
    end
  end

  assign perf_upd_cnt = upd_cnt_q;
  assign perf_sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_ctr_table_updater.sv
// Bench for ctr_table_updater: macro model with old-data read-during-write, counter-array reference.
module tb_ctr_table_updater;

  logic        clock;
  logic        reset_n;
  logic        pred_valid;
  logic [8:0]  pred_idx;
  logic        pred_resp_valid;
  logic [15:0] pred_data;
  logic        upd_valid;
  logic        upd_ready;
  logic [8:0]  upd_idx;
  logic [2:0]  upd_lane;
  logic        upd_taken;
  logic        init_done;
  logic        R0_en;
  logic [8:0]  R0_addr;
  logic [15:0] R0_data = '0;
  logic        W0_en;
  logic [8:0]  W0_addr;
  logic [15:0] W0_data;
  logic [7:0]  W0_mask;
`ifdef CTR_TABLE_UPD_PERF_EN
  logic [31:0] perf_upd_cnt;
  logic [31:0] perf_sat_cnt;
`endif

  ctr_table_updater dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .pred_valid      (pred_valid),
    .pred_idx        (pred_idx),
    .pred_resp_valid (pred_resp_valid),
    .pred_data       (pred_data),
    .upd_valid       (upd_valid),
    .upd_ready       (upd_ready),
    .upd_idx         (upd_idx),
    .upd_lane        (upd_lane),
    .upd_taken       (upd_taken),
    .init_done       (init_done),
    .R0_en           (R0_en),
    .R0_addr         (R0_addr),
    .R0_data         (R0_data),
    .W0_en           (W0_en),
    .W0_addr         (W0_addr),
    .W0_data         (W0_data),
    .W0_mask         (W0_mask)
`ifdef CTR_TABLE_UPD_PERF_EN
    ,
    .perf_upd_cnt    (perf_upd_cnt),
    .perf_sat_cnt    (perf_sat_cnt)
`endif
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- macro model (read returns pre-write data) ----------------
  logic [15:0] mem [512];

  always @(posedge clock) begin
    logic [15:0] w;
    if (R0_en) R0_data <= mem[R0_addr];
    if (W0_en) begin
      w = mem[W0_addr];
      for (int l = 0; l < 8; l++)
        if (W0_mask[l]) w[2*l +: 2] = W0_data[2*l +: 2];
      mem[W0_addr] <= w;
    end
  end

  // ---------------- reference model and scoreboard ----------------
  int          ref_ctr [512][8];
  int          exp_upd_cnt = 0;
  int          exp_sat_cnt = 0;
  logic [15:0] exp_q [$];
  logic [32:0] wr_exp_q [$];
  logic [15:0] last_pred;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_word(int idx);
    logic [15:0] w;
    w = '0;
    for (int l = 0; l < 8; l++) w = w | (16'(ref_ctr[idx][l]) << (2 * l));
    return w;
  endfunction

  function automatic logic [63:0] all_outputs();
    return 64'({pred_resp_valid, pred_data, upd_ready, init_done, R0_en, R0_addr,
                W0_en, W0_addr, W0_data, W0_mask});
  endfunction

  // ---------------- driver tasks ----------------
  task automatic sweep_cycle(input int k);
    @(posedge clock); #1;
    pred_valid = 1'($urandom_range(0, 1));
    pred_idx   = 9'($urandom_range(0, 511));
    upd_valid  = 1'($urandom_range(0, 1));
    upd_idx    = 9'($urandom_range(0, 511));
    @(negedge clock);
    chk("sweep_w0_en",   W0_en, 1);
    chk("sweep_w0_addr", W0_addr, k);
    chk("sweep_w0_mask", W0_mask, 8'hFF);
    chk("sweep_w0_data", W0_data, 16'hAAAA);
    chk("sweep_upd_ready", upd_ready, 0);
    chk("sweep_r0_en",   R0_en, 0);
    chk("sweep_pred_resp", pred_resp_valid, 0);
    chk("sweep_init_done", init_done, 0);
  endtask

  task automatic step(input bit pv, input int pidx, input bit uv, input int uidx,
                      input int ulane, input bit ut, output bit acc);
    int old_v, new_v;
    logic [15:0] e;
    logic [32:0] we;
    @(posedge clock); #1;
    pred_valid = pv;
    pred_idx   = 9'(pidx);
    upd_valid  = uv;
    upd_idx    = 9'(uidx);
    upd_lane   = 3'(ulane);
    upd_taken  = ut;
    @(negedge clock);
    chk("pred_resp_valid", pred_resp_valid, exp_q.size() != 0);
    if (pred_resp_valid && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("pred_data", pred_data, e);
      last_pred = pred_data;
    end
    exp_q.delete();
    chk("w0_en", W0_en, wr_exp_q.size() != 0);
    if (W0_en && wr_exp_q.size() != 0) begin
      we = wr_exp_q.pop_front();
      chk("w0_write", {W0_addr, W0_mask, W0_data}, we);
    end
    wr_exp_q.delete();
    chk("upd_ready", upd_ready, !pv);
    chk("r0_en", R0_en, pv | uv);
    if (pv | uv) chk("r0_addr", R0_addr, pv ? pidx : uidx);
    chk("init_done", init_done, 1);
    acc = 1'b0;
    if (pv) begin
      exp_q.push_back(ref_word(pidx));
    end else if (uv) begin
      acc   = 1'b1;
      old_v = ref_ctr[uidx][ulane];
      new_v = ut ? ((old_v < 3) ? old_v + 1 : 3) : ((old_v > 0) ? old_v - 1 : 0);
      ref_ctr[uidx][ulane] = new_v;
      wr_exp_q.push_back({9'(uidx), 8'(1 << ulane), 16'(new_v) << (2 * ulane)});
      exp_upd_cnt++;
      if (new_v == old_v) exp_sat_cnt++;
    end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, a);
  endtask

  // ---------------- main sequence ----------------
  bit acc;
  bit pv, have_u, ut;
  int ui, ul;
`ifdef CTR_TABLE_UPD_PERF_EN
  logic [31:0] pu0, ps0;
`endif

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
    reset_n    = 1'b0;
    pred_valid = 1'b0;
    pred_idx   = '0;
    upd_valid  = 1'b0;
    upd_idx    = '0;
    upd_lane   = '0;
    upd_taken  = 1'b0;
    last_pred  = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs", all_outputs(), 0);

    // Partial sweep, then reset at address 200.
    @(posedge clock); #1 reset_n = 1'b1;
    for (int k = 0; k <= 200; k++) sweep_cycle(k);
    #1 reset_n = 1'b0;
    #1 chk("midsweep_reset_outputs", all_outputs(), 0);
    @(posedge clock); #1 reset_n = 1'b1;

    // Full sweep from address 0.
    for (int k = 0; k < 512; k++) sweep_cycle(k);
    for (int i = 0; i < 512; i++)
      for (int l = 0; l < 8; l++) ref_ctr[i][l] = 2;
    idle(1);

    // Saturating increment back-to-back, then lookup.
    step(0, 0, 1, 5, 3, 1, acc);
    step(0, 0, 1, 5, 3, 1, acc);
    step(1, 5, 0, 0, 0, 0, acc);
    idle(1);
    chk("pred_idx5", last_pred, 16'hAAEA);

    // Three decrements back-to-back, lookup immediately after.
    step(0, 0, 1, 7, 0, 0, acc);
    step(0, 0, 1, 7, 0, 0, acc);
    step(0, 0, 1, 7, 0, 0, acc);
    step(1, 7, 0, 0, 0, 0, acc);
    idle(1);
    chk("pred_idx7", last_pred, 16'hAAA8);

    // Lookup and update together for three cycles: update held until cycle 4.
    for (int i = 0; i < 3; i++) step(1, $urandom_range(0, 511), 1, 9, 1, 1, acc);
    step(0, 0, 1, 9, 1, 1, acc);
    idle(2);

`ifdef CTR_TABLE_UPD_PERF_EN
    pu0 = perf_upd_cnt;
    ps0 = perf_sat_cnt;
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 2, 1, acc);
    idle(2);
    chk("perf_upd_delta", perf_upd_cnt - pu0, 4);
    chk("perf_sat_delta", perf_sat_cnt - ps0, 3);
`endif

    // Random traffic on a narrow index range to force bypass collisions.
    have_u = 1'b0;
    ui = 0; ul = 0; ut = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      pv = ($urandom_range(0, 9) < 4);
      if (!have_u && ($urandom_range(0, 9) < 7)) begin
        have_u = 1'b1;
        ui     = $urandom_range(0, 15);
        ul     = $urandom_range(0, 7);
        ut     = 1'($urandom_range(0, 1));
      end
      step(pv, $urandom_range(0, 15), have_u, ui, ul, ut, acc);
      if (acc) have_u = 1'b0;
    end
    idle(2);

`ifdef CTR_TABLE_UPD_PERF_EN
    chk("perf_upd_total", perf_upd_cnt, exp_upd_cnt);
    chk("perf_sat_total", perf_sat_cnt, exp_sat_cnt);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ctr_table_updater.md
Name: ctr_table_updater

Overview:
- Control stage directly in front of the 512x16 two-bit-counter SRAM macro (8 lanes x 2 bits, per-lane write mask, 1-cycle read latency).
- Owns both macro ports:
  - R0 (read) is shared between prediction lookups and update read-modify-write (RMW).
  - W0 (write) carries saturating-counter updates and the post-reset init sweep.
- Returns prediction words to the predictor pipeline.

Parameters:
- IDX_W, 9, table index width (512 entries)
- LANES, 8, counters per entry
- CTR_W, 2, bits per counter
- INIT_CTR, 2'b10, init-sweep value written to every lane (weakly taken)

Ports:
- clock  in  1  single clock for the block and both macro ports
- reset_n  in  1  asynchronous reset, active-low
- pred_valid  in  1  prediction lookup request
- pred_idx  in  9  lookup index
- pred_resp_valid  out  1  pred_data valid (1 cycle after pred_valid)
- pred_data  out  16  all 8 counters of the entry
- upd_valid  in  1  update request
- upd_ready  out  1  update accepted when valid&ready
- upd_idx  in  9  entry index
- upd_lane  in  3  counter lane
- upd_taken  in  1  1 = increment, 0 = decrement
- init_done  out  1  init sweep complete
- R0_en  out  1  macro read enable
- R0_addr  out  9  macro read address
- R0_data  in  16  macro read data (valid the cycle after R0_en)
- W0_en  out  1  macro write enable
- W0_addr  out  9  macro write address
- W0_data  out  16  macro write data
- W0_mask  out  8  per-lane write mask

Behaviour:
- Reset (async, reset_n=0):
  - All outputs 0; init_done=0.
  - Pipeline valids cleared; sweep counter=0.
  - FSM returns to INIT. Reset mid-sweep or mid-RMW restarts the sweep; a half-done RMW is discarded.
- FSM states: INIT, RUN.
- INIT:
  - One write per cycle: W0_en=1, W0_addr=counter, W0_mask=8'hFF, W0_data = INIT_CTR replicated 8x.
  - 512 cycles total. Counter wraps 511 -> 0, then go to RUN with init_done=1.
  - In INIT: upd_ready=0; pred_valid ignored; pred_resp_valid stays 0.
- RUN read arbitration:
  - Prediction has priority: if pred_valid, R0_en=1, R0_addr=pred_idx, upd_ready=0.
  - Otherwise upd_ready=1: on upd_valid, R0_en=1, R0_addr=upd_idx, and (idx, lane, taken) are latched into S1.
  - R0_en=0 when idle.
- Prediction response:
  - pred_resp_valid=1 exactly one cycle after an accepted lookup.
  - pred_data = R0_data after bypass.
- Update S1 (cycle after accept):
  - old = lane field of the bypassed R0_data.
  - new = taken ? min(old+1, 3) : max(old-1, 0), saturating 2-bit arithmetic.
  - Drive W0_en=1, W0_addr=idx, W0_mask=one-hot(lane), new placed in the lane's field, other fields 0.
  - Throughput: 1 update/cycle. Write latency: 1 cycle after accept.
- Bypass (mandatory; macro read-during-write behaviour is not relied on):
  - Register the last W0 write (valid, idx, lane, value).
  - When the data returned for a read issued in cycle t matches the idx of a W0 write in cycle t, replace that lane field with the written value.
  - Applies to both pred_data and the update old value.
  - Covers back-to-back updates to the same counter.
- Saturated updates (new == old) are still written; there is no write suppression.
- Simultaneous pred_valid & upd_valid: the lookup wins and the update waits; upd_valid must stay asserted until accepted.

Optional Feature:
- Macro: CTR_TABLE_UPD_PERF_EN.
- Defined:
  - Adds outputs perf_upd_cnt[31:0] (accepted updates) and perf_sat_cnt[31:0] (updates with new == old).
  - Both reset to 0, wrap at 2^32, do not count during INIT.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Shared package ctr_table_pkg:
  - Constants IDX_W, LANES, CTR_W, ENTRIES=512, INIT_CTR.
  - Typedef ctr_t (2 bits), entry_t (16 bits), upd_req_t {idx, lane, taken}.
  - Function sat_update(old, taken).
- Sub-module ctr_lane_bypass: combinational field merge of {raw word, last-write record, read idx} -> corrected word. Used for both the prediction path and the update path.

Test Plan:
- Reset then idle 512 cycles -> W0 sweep addresses 0..511, mask FF, data 16'hAAAA; init_done=1 on cycle 513; upd_ready=0 throughout the sweep.
- After init, upd idx=5 lane=3 taken=1 x2 back-to-back -> writes mask 8'h08 with lane3=2'b11 both times (second is saturated); pred idx=5 -> 16'hAAEA.
- Back-to-back upd idx=7 lane=0 taken=0 x3 -> lane0 goes 01, 00, 00 via bypass; pred idx=7 next cycle -> 16'hAAA8.
- pred_valid and upd_valid both high for 3 cycles -> 3 pred responses, update accepted on cycle 4, its write on cycle 5.
- Assert reset_n low at sweep address 200 -> all outputs 0; after release the sweep restarts at 0 and init_done stays 0 for 512 cycles.
- With CTR_TABLE_UPD_PERF_EN, 4 updates to idx=1 lane=2 taken=1 -> perf_upd_cnt=4, perf_sat_cnt=3.
